fill_cmd_dispatch: RTL and testbench

- Command front-end directly upstream of the fill stage.
- Buffers fill commands from the host decoder in a small FIFO and normalises rectangle coordinates.
- Drives the fill stage's command fields and one-cycle fill_en start pulse, then waits for its done before issuing the next command.
- Guarantees the fill stage sees stable operands for the whole operation.

---
 rtl/fill_cmd_dispatch_if.sv | 16 +
 rtl/fill_cmd_dispatch.sv | 192 +++++++++++++++++++
 tb/tb_fill_cmd_dispatch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_cmd_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : fill_cmd_dispatch_if
// Brief    : Host-decoder to dispatcher command channel (valid/ready + data).
// Revision : 1.0 - initial release
// ============================================================================
interface fill_cmd_dispatch_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [75:0] cmd_data;

   // master: host decoder side; slave: dispatcher side
   modport master (output cmd_valid, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/fill_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fill_cmd_dispatch
// Brief    : Command FIFO and fill-stage issuer with coordinate normalisation.
//            Optional WAIT watchdog enabled by macro FILL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fill_cmd_dispatch #(
   parameter int DEPTH    = 4,
   parameter int CNT_BITS = 3
`ifdef FILL_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic                clk,
   input  logic                n_rst,
   fill_cmd_dispatch_if.slave  cmd_if,
   output logic                fill_en,
   input  logic                done,
   output logic                fill_type,
   output logic [47:0]         coordinates,
   output logic [1:0]          texture_code,
   output logic [23:0]         color_code,
   output logic                layer_num,
   output logic                busy,
   output logic [CNT_BITS-1:0] cmd_count,
   output logic                err_timeout
);

   localparam int c_PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [75:0]         r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [CNT_BITS-1:0] r_count;

   logic                r_fill_en;
   logic                r_busy;
   logic                r_fill_type;
   logic [47:0]         r_coords;
   logic [1:0]          r_texture;
   logic [23:0]         r_color;
   logic                r_layer;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [75:0]         w_head;
   logic [11:0]         w_x1;
   logic [11:0]         w_y1;
   logic [11:0]         w_x2;
   logic [11:0]         w_y2;
   logic                w_swap_x;
   logic                w_swap_y;

   assign w_full   = (r_count == CNT_BITS'(DEPTH));
   assign w_empty  = (r_count == '0);

   // Held low while in reset so the host never sees a ready it cannot use.
   assign cmd_if.cmd_ready = n_rst & ~w_full;
   assign w_push   = cmd_if.cmd_valid & cmd_if.cmd_ready;
   assign w_pop    = (r_state == S_IDLE) & ~w_empty;

   assign w_head   = r_mem[r_rd_ptr];
   assign w_x1     = w_head[74:63];
   assign w_y1     = w_head[62:51];
   assign w_x2     = w_head[50:39];
   assign w_y2     = w_head[38:27];
   assign w_swap_x = (w_x1 > w_x2);
   assign w_swap_y = (w_y1 > w_y2);

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= cmd_if.cmd_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_BITS'(1);
            2'b01:   r_count <= r_count - CNT_BITS'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FILL_TIMEOUT_EN
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmo_cnt;
   logic        r_err_timeout;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_fill_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_fill_type <= 1'b0;
         r_coords    <= '0;
         r_texture   <= '0;
         r_color     <= '0;
         r_layer     <= 1'b0;
`ifdef FILL_TIMEOUT_EN
         r_tmo_cnt     <= '0;
         r_err_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state     <= S_ISSUE;
                  r_fill_en   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_fill_type <= w_head[75];
                  r_coords    <= {w_swap_x ? w_x2 : w_x1,
                                  w_swap_y ? w_y2 : w_y1,
                                  w_swap_x ? w_x1 : w_x2,
                                  w_swap_y ? w_y1 : w_y2};
                  r_texture   <= w_head[26:25];
                  r_color     <= w_head[24:1];
                  r_layer     <= w_head[0];
               end
            end
            S_ISSUE: begin
               r_state   <= S_WAIT;
               r_fill_en <= 1'b0;
`ifdef FILL_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
            end
            S_WAIT: begin
               if (done) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
`ifdef FILL_TIMEOUT_EN
               else if (r_tmo_cnt == c_TMO_LAST) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_err_timeout <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 16'd1;
               end
`endif
            end
            default: begin
               r_state   <= S_IDLE;
               r_fill_en <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef FILL_TIMEOUT_EN
   assign err_timeout = r_err_timeout;
`else
   assign err_timeout = 1'b0;
`endif

   assign fill_en      = r_fill_en;
   assign busy         = r_busy;
   assign fill_type    = r_fill_type;
   assign coordinates  = r_coords;
   assign texture_code = r_texture;
   assign color_code   = r_color;
   assign layer_num    = r_layer;
   assign cmd_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fill_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fill_cmd_dispatch
// Brief    : Directed self-checking bench for fill_cmd_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fill_cmd_dispatch;
   localparam int DEPTH    = 4;
   localparam int CNT_BITS = 3;
   localparam int TMO      = 8;

   logic                clk   = 1'b0;
   logic                n_rst = 1'b1;
   logic                done  = 1'b0;
   logic                fill_en;
   logic                fill_type;
   logic [47:0]         coordinates;
   logic [1:0]          texture_code;
   logic [23:0]         color_code;
   logic                layer_num;
   logic                busy;
   logic [CNT_BITS-1:0] cmd_count;
   logic                err_timeout;

   fill_cmd_dispatch_if cmd_if ();

   always #5 clk = ~clk;

   fill_cmd_dispatch #(
      .DEPTH          (DEPTH),
      .CNT_BITS       (CNT_BITS)
`ifdef FILL_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TMO)
`endif
   ) u_dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .cmd_if       (cmd_if),
      .fill_en      (fill_en),
      .done         (done),
      .fill_type    (fill_type),
      .coordinates  (coordinates),
      .texture_code (texture_code),
      .color_code   (color_code),
      .layer_num    (layer_num),
      .busy         (busy),
      .cmd_count    (cmd_count),
      .err_timeout  (err_timeout)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [75:0] mk(input logic ft, input int x1, input int y1,
                                      input int x2, input int y2, input logic [1:0] tex,
                                      input logic [23:0] col, input logic ly);
      return {ft, 12'(x1), 12'(y1), 12'(x2), 12'(y2), tex, col, ly};
   endfunction

   // Expected field image of a popped command: rectangle corners sorted per axis.
   function automatic logic [75:0] norm(input logic [75:0] c);
      int x1, y1, x2, y2;
      x1 = int'(c[74:63]);
      y1 = int'(c[62:51]);
      x2 = int'(c[50:39]);
      y2 = int'(c[38:27]);
      return {c[75], 12'((x1 < x2) ? x1 : x2), 12'((y1 < y2) ? y1 : y2),
              12'((x1 < x2) ? x2 : x1), 12'((y1 < y2) ? y2 : y1), c[26:0]};
   endfunction

   // Reference: a queue of pending commands plus which phase of an operation we are in
   // (0 = nothing in flight, 1 = start-pulse cycle, 2 = awaiting completion).
   logic [75:0] m_q [$];
   int          m_phase  = 0;
   int          m_wcnt   = 0;
   bit          m_err    = 1'b0;
   logic [75:0] m_fields = '0;

   always @(posedge clk or negedge n_rst) begin
      bit acc;
      if (!n_rst) begin
         m_q.delete();
         m_phase  = 0;
         m_wcnt   = 0;
         m_err    = 1'b0;
         m_fields = '0;
      end else begin
         acc = cmd_if.cmd_valid && (m_q.size() < DEPTH);
         case (m_phase)
            0: if (m_q.size() > 0) begin
                  m_fields = norm(m_q.pop_front());
                  m_phase  = 1;
               end
            1: begin
                  m_phase = 2;
                  m_wcnt  = 0;
               end
            default: if (done) begin
                  m_phase = 0;
               end
`ifdef FILL_TIMEOUT_EN
               else if (m_wcnt == TMO - 1) begin
                  m_phase = 0;
                  m_err   = 1'b1;
               end else begin
                  m_wcnt++;
               end
`endif
         endcase
         if (acc) m_q.push_back(cmd_if.cmd_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_ready", cmd_if.cmd_ready, n_rst && (m_q.size() < DEPTH));
         check("m_count", cmd_count, m_q.size());
         check("m_fill_en", fill_en, m_phase == 1);
         check("m_busy", busy, m_phase != 0);
         check("m_fields", {fill_type, coordinates, texture_code, color_code, layer_num}, m_fields);
         check("m_err_timeout", err_timeout, m_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [75:0] d);
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = d;
      while (!acc && guard < 40) begin
         acc = cmd_if.cmd_ready;
         tick();
         guard++;
      end
      cmd_if.cmd_valid = 1'b0;
      check("push_accepted", acc, 1'b1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((cmd_count != 0 || busy) && guard < 300) begin
         if (busy && !fill_en) done = 1'b1;
         tick();
         done = 1'b0;
         guard++;
      end
      check("drained", {cmd_count, busy}, '0);
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_data  = '0;
      #2 n_rst = 1'b0;
      chk_en = 1'b1;

      // Reset with a valid command presented
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = mk(1'b0, 1, 2, 3, 4, 2'd1, 24'h123456, 1'b1);
      repeat (3) tick();
      check("rst_fill_en", fill_en, 0);
      check("rst_busy", busy, 0);
      check("rst_count", cmd_count, 0);
      check("rst_ready", cmd_if.cmd_ready, 0);
      check("rst_coords", coordinates, 0);
      n_rst = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      check("first_push_count", cmd_count, 1);
      check("first_not_issued", fill_en, 0);
      tick();
      check("first_issue", fill_en, 1);
      tick();
      check("first_pulse_width", fill_en, 0);
      check("first_busy_wait", busy, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("first_done_idle", busy, 0);

      // Single command with unordered corners
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = mk(1'b1, 100, 50, 20, 300, 2'd2, 24'hABCDEF, 1'b1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      check("norm_not_issued", fill_en, 0);
      tick();
      check("norm_issue", fill_en, 1);
      check("norm_coords", coordinates, {12'd20, 12'd50, 12'd100, 12'd300});
      repeat (9) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("norm_idle", busy, 0);
      check("norm_hold", coordinates, {12'd20, 12'd50, 12'd100, 12'd300});
      check("norm_color", color_code, 24'hABCDEF);

      // done while idle and during the start-pulse cycle
      done = 1'b1;
      repeat (2) tick();
      done = 1'b0;
      check("idle_done_busy", busy, 0);
      check("idle_done_count", cmd_count, 0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = mk(1'b0, 7, 7, 7, 7, 2'd3, 24'h000001, 1'b0);
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      check("issue_cycle", fill_en, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("issue_done_ignored", busy, 1);
      check("equal_coords", coordinates, {12'd7, 12'd7, 12'd7, 12'd7});
      repeat (2) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("issue_done_later", busy, 0);

      // Burst into a stalled dispatcher until the FIFO is full
      for (int i = 0; i < 5; i++) begin
         push_cmd(mk(i[0], 4000 - i, i, i, 4000 - i, 2'(i), 24'(i * 3), i[1]));
      end
      check("full_count", cmd_count, 4);
      check("full_ready", cmd_if.cmd_ready, 0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = mk(1'b1, 4095, 0, 0, 4095, 2'd0, 24'hFFFFFF, 1'b1);
      repeat (2) tick();
      check("full_held", cmd_count, 4);
      done = 1'b1;
      tick();
      done = 1'b0;
      push_cmd(mk(1'b1, 4095, 0, 0, 4095, 2'd0, 24'hFFFFFF, 1'b1));
      check("refill_count", cmd_count, 4);
      drain();

      // Reset while waiting with two queued
      for (int i = 0; i < 3; i++) begin
         push_cmd(mk(1'b0, 10 + i, 20, 30, 40, 2'd1, 24'h0F0F0F, 1'b0));
      end
      tick();
      check("pre_rst_busy", busy, 1);
      check("pre_rst_count", cmd_count, 2);
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_fill_en", fill_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_count", cmd_count, 0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("post_rst_no_fill", fill_en, 0);
      end

`ifdef FILL_TIMEOUT_EN
      push_cmd(mk(1'b0, 5, 6, 7, 8, 2'd1, 24'h111111, 1'b0));
      push_cmd(mk(1'b1, 9, 9, 1, 1, 2'd2, 24'h222222, 1'b1));
      repeat (30) tick();
      check("tmo_err", err_timeout, 1);
      check("tmo_drained", cmd_count, 0);
      drain();
      check("tmo_sticky", err_timeout, 1);
`endif

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
